// File: rtl/pc_redirect_unit_if.sv
// pc_redirect_unit_if
//   Bundles the next-PC select, candidate targets and stall request going into
//   the PC sequencer, and the fetch address / flush / status coming out.
//   master : branch-decision + hazard side (drives select, targets, stall)
//   slave  : pc_redirect_unit (drives Pc, PcPlus1, Flush, Pending, RedirectCount)
interface pc_redirect_unit_if #(
    parameter int WIDTH = 16
);
    logic [1:0]       PcCtrl;
    logic [WIDTH-1:0] BranchTarget;
    logic [WIDTH-1:0] RegTarget;
    logic             Stall;
    logic [WIDTH-1:0] Pc;
    logic [WIDTH-1:0] PcPlus1;
    logic             Flush;
    logic             Pending;
    logic [15:0]      RedirectCount;

    modport master (
        output PcCtrl, BranchTarget, RegTarget, Stall,
        input  Pc, PcPlus1, Flush, Pending, RedirectCount
    );

    modport slave (
        input  PcCtrl, BranchTarget, RegTarget, Stall,
        output Pc, PcPlus1, Flush, Pending, RedirectCount
    );
endinterface

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit
//   Program-counter register and redirect sequencer. Selects the next fetch
//   address from hold / PC+1 / register target / branch target. A redirect
//   that arrives while Stall is high is parked in PendTarget and applied on
//   the first unstalled edge; the first parked redirect wins.
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset
//     bus       : pc_redirect_unit_if.slave
//                 in : PcCtrl, BranchTarget, RegTarget, Stall
//                 out: Pc (registered), PcPlus1 (comb), Flush (registered
//                      one-cycle pulse), Pending (state decode),
//                      RedirectCount (saturating)
module pc_redirect_unit #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    pc_redirect_unit_if.slave     bus
);
    typedef enum logic {RUN, PEND} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pc_q, pc_nxt;
    logic [WIDTH-1:0] pend_q, pend_nxt;
    logic             flush_q, flush_nxt;
    logic [15:0]      cnt_q, cnt_nxt;

    logic             redir_req;
    logic [WIDTH-1:0] req_tgt;
    logic [15:0]      cnt_inc;

    // PcCtrl 2/3 are the redirect encodings; bit 0 picks branch over register.
    assign redir_req = bus.PcCtrl[1];
    assign req_tgt   = bus.PcCtrl[0] ? bus.BranchTarget : bus.RegTarget;
    assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            flush_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            pend_q  <= pend_nxt;
            flush_q <= flush_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        pend_nxt  = pend_q;
        flush_nxt = 1'b0;
        cnt_nxt   = cnt_q;
        unique case (state)
            RUN: begin
                if (bus.Stall) begin
                    // Stall plus redirect always defers, never applies now.
                    if (redir_req) begin
                        pend_nxt  = req_tgt;
                        state_nxt = PEND;
                    end
                end else begin
                    unique case (bus.PcCtrl)
                        2'd0: pc_nxt = pc_q;
                        2'd1: pc_nxt = pc_q + 1'b1;
                        default: begin
                            pc_nxt    = req_tgt;
                            flush_nxt = 1'b1;
                            cnt_nxt   = cnt_inc;
                        end
                    endcase
                end
            end
            PEND: begin
                // Requests seen while parked are dropped; PcCtrl is also
                // ignored on the release edge.
                if (!bus.Stall) begin
                    pc_nxt    = pend_q;
                    flush_nxt = 1'b1;
                    cnt_nxt   = cnt_inc;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    assign bus.Pc            = pc_q;
    assign bus.PcPlus1       = pc_q + 1'b1;
    assign bus.Flush         = flush_q;
    assign bus.Pending       = (state == PEND);
    assign bus.RedirectCount = cnt_q;
endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

Program-counter register and redirect sequencer for the 16-bit pipelined CPU. It consumes the 2-bit `PcCtrl` select produced by the branch-decision logic, together with the candidate targets, and produces the fetch address for the next cycle. It defers a redirect that arrives during a pipeline stall and applies it once the stall clears. It also emits a one-cycle flush pulse to the IF/ID register and keeps a saturating count of redirects taken.

## Interface
Parameters:
- `WIDTH`, 16: PC / address width (word addressed).
- `RESET_PC`, 0: PC value loaded on reset.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `PcCtrl`  in  2  next-PC select: 0 = hold, 1 = sequential (PC+1), 2 = register target, 3 = branch target.
- `BranchTarget`  in  WIDTH  PC-relative target from the adder in the ID stage.
- `RegTarget`  in  WIDTH  register-indirect target (JR), from the register-file read port.
- `Stall`  in  1  hazard unit freeze request; PC must not advance while high.
- `Pc`  out  WIDTH  current fetch address (registered).
- `PcPlus1`  out  WIDTH  `Pc + 1` mod 2^WIDTH (combinational from `Pc`).
- `Flush`  out  1  registered one-cycle pulse; kills the instruction in IF/ID.
- `Pending`  out  1  high while a deferred redirect is held (state PEND).
- `RedirectCount`  out  16  saturating count of redirects applied.

## Operation
- A redirect request is `PcCtrl` = 2 or 3. Its target is `RegTarget` or `BranchTarget` respectively, sampled in the request cycle.
- FSM states:
  - **RUN**: normal operation.
  - **PEND**: a redirect is latched in the internal `PendTarget` register.
- RUN, `Stall`=0:
  - `PcCtrl`=0: `Pc` holds.
  - `PcCtrl`=1: `Pc` ← `PcPlus1`.
  - `PcCtrl`=2 or 3: `Pc` ← selected target, `Flush` ← 1, `RedirectCount` increments.
- RUN, `Stall`=1:
  - `Pc` holds.
  - A redirect request latches its target into `PendTarget` and moves to PEND.
  - `PcCtrl`=0/1 with `Stall`=1 does nothing.
- PEND, `Stall`=1:
  - `Pc` and `PendTarget` hold.
  - New redirect requests are ignored; the first latched redirect wins.
- PEND, `Stall`=0:
  - `Pc` ← `PendTarget`, `Flush` ← 1, `RedirectCount` increments, state → RUN.
  - `PcCtrl` in that cycle is ignored.
- `Flush` is 0 on every edge that does not apply a redirect, so it is never high for two consecutive cycles unless two redirects are applied back to back.
- Arithmetic and width rules:
  - `PcPlus1` wraps: 0xFFFF → 0x0000 (for `WIDTH`=16).
  - `RedirectCount` saturates at 0xFFFF and does not wrap.
  - Targets are used unmodified at full `WIDTH`.

## Timing
- Reset (async, effective immediately):
  - `Pc`=`RESET_PC`, state=RUN, `Pending`=0, `Flush`=0, `RedirectCount`=0, `PendTarget`=0.
  - Release is synchronous to the next `clk` edge.
- Latency:
  - Redirect in RUN with no stall: the new `Pc` and `Flush`=1 are visible one cycle after the request cycle.
  - Deferred redirect: applied on the first edge where `Stall`=0. `Pc` and `Flush` update after that edge.
- `Pending` is a direct decode of state (registered). It rises the cycle after the stalled request and falls together with the `Flush` pulse.
- Reset asserted mid-PEND discards `PendTarget`, and no `Flush` is issued.
- `Stall` and a redirect in the same cycle always defer; they never apply immediately.
- Inputs must be stable a setup time before the rising edge. There is no combinational path from the inputs to `Pc`, `Flush` or `Pending`.

## Test plan
- **Reset and sequential run**: reset with `RESET_PC`=0x0000, release, `PcCtrl`=1 for 4 cycles → `Pc` 0x0000, 0x0001, 0x0002, 0x0003, 0x0004; `Flush`=0 throughout; `RedirectCount`=0.
- **Branch taken**: at `Pc`=0x0010 drive `PcCtrl`=3, `BranchTarget`=0x0040 → next cycle `Pc`=0x0040, `Flush`=1 for exactly one cycle, `RedirectCount`=1.
- **Deferred JR**: `Stall`=1 with `PcCtrl`=2, `RegTarget`=0x1234 → `Pending`=1 and `Pc` held. Hold `Stall` 3 cycles while driving `PcCtrl`=3, `BranchTarget`=0x5555. Drop `Stall` → `Pc`=0x1234 (not 0x5555), `Flush` pulse, `Pending`=0.
- **Wrap-around**: force `Pc`=0xFFFF via `PcCtrl`=3, `BranchTarget`=0xFFFF, then `PcCtrl`=1 → `Pc`=0x0000, `PcPlus1`=0x0001.
- **Reset mid-PEND**: enter PEND with target 0x0200, assert `rst` asynchronously mid-cycle → `Pc`=`RESET_PC` immediately, `Pending`=0. After release there is no `Flush` and `Pc` never reaches 0x0200.
- **Counter saturation and hold**: preload `RedirectCount` to 0xFFFE via back-to-back redirects (or a forced value), apply 3 more redirects → count 0xFFFF and stays there. `PcCtrl`=0 for 2 cycles → `Pc` unchanged.
